// File: rtl/warp_sched_lite_pkg.sv
// Shared types and default configuration for the warp scheduler slice.
package warp_sched_lite_pkg;

  localparam int unsigned          DEF_NUM_WARPS   = 4;
  localparam int unsigned          DEF_NUM_THREADS = 4;
  localparam int unsigned          DEF_PC_BITS     = 31;
  localparam int unsigned          DEF_UUID_WIDTH  = 44;
  localparam logic [DEF_PC_BITS-1:0] DEF_STARTUP_PC = 31'h20000000;

  localparam int unsigned NW_WIDTH = $clog2(DEF_NUM_WARPS);

  // Schedule entry as consumed by fetch, in fetch's field order.
  typedef struct packed {
    logic [DEF_UUID_WIDTH-1:0]  uuid;
    logic [NW_WIDTH-1:0]        wid;
    logic [DEF_NUM_THREADS-1:0] tmask;
    logic [DEF_PC_BITS-1:0]     PC;
  } sched_data_t;

endpackage

// File: rtl/warp_sched_lite_rr_warp_arbiter.sv
// Combinational round-robin picker: first request strictly after the pointer.
module rr_warp_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_onehot_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               gnt_valid_o
);

  logic [IDX_W-1:0] idx;

  // Scan ptr+1 .. ptr+NUM_REQ; index wraps naturally since NUM_REQ is 2**IDX_W.
  always_comb begin
    gnt_onehot_o = '0;
    gnt_idx_o    = '0;
    gnt_valid_o  = 1'b0;
    idx          = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = ptr_i + IDX_W'(i);
      if (!gnt_valid_o && req_i[idx]) begin
        gnt_valid_o       = 1'b1;
        gnt_idx_o         = idx;
        gnt_onehot_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/warp_sched_lite.sv
// Warp scheduler: per-warp PC/tmask/active/stalled state, round-robin issue
// onto a registered valid/ready schedule interface feeding fetch.
module warp_sched_lite
  import warp_sched_lite_pkg::*;
#(
  parameter int unsigned         NUM_WARPS   = DEF_NUM_WARPS,
  parameter int unsigned         NUM_THREADS = DEF_NUM_THREADS,
  parameter int unsigned         PC_BITS     = DEF_PC_BITS,
  parameter int unsigned         UUID_WIDTH  = DEF_UUID_WIDTH,
  parameter logic [PC_BITS-1:0]  STARTUP_PC  = PC_BITS'(DEF_STARTUP_PC)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         spawn_valid,
  input  logic [$clog2(NUM_WARPS)-1:0] spawn_wid,
  input  logic [PC_BITS-1:0]           spawn_PC,
  input  logic [NUM_THREADS-1:0]       spawn_tmask,
  input  logic                         resume_valid,
  input  logic [$clog2(NUM_WARPS)-1:0] resume_wid,
  input  logic [PC_BITS-1:0]           resume_PC,
  input  logic [NUM_THREADS-1:0]       resume_tmask,
  output logic                         sched_valid,
  input  logic                         sched_ready,
  output logic [$clog2(NUM_WARPS)-1:0] sched_wid,
  output logic [PC_BITS-1:0]           sched_PC,
  output logic [NUM_THREADS-1:0]       sched_tmask,
  output logic [UUID_WIDTH-1:0]        sched_uuid,
  output logic                         busy
);

  localparam int unsigned WID_W = $clog2(NUM_WARPS);

  logic [NUM_WARPS-1:0]   active_q, active_d;
  logic [NUM_WARPS-1:0]   stalled_q, stalled_d;
  logic [PC_BITS-1:0]     pc_q [NUM_WARPS];
  logic [PC_BITS-1:0]     pc_d [NUM_WARPS];
  logic [NUM_THREADS-1:0] tmask_q [NUM_WARPS];
  logic [NUM_THREADS-1:0] tmask_d [NUM_WARPS];
  logic [UUID_WIDTH-1:0]  uuid_q, uuid_d;
  logic [WID_W-1:0]       rr_q, rr_d;

  logic                   out_valid_q, out_valid_d;
  logic [WID_W-1:0]       out_wid_q, out_wid_d;
  logic [PC_BITS-1:0]     out_pc_q, out_pc_d;
  logic [NUM_THREADS-1:0] out_tmask_q, out_tmask_d;
  logic [UUID_WIDTH-1:0]  out_uuid_q, out_uuid_d;

  logic [NUM_WARPS-1:0]   eligible;
  logic [NUM_WARPS-1:0]   gnt_onehot;
  logic [WID_W-1:0]       gnt_idx;
  logic                   gnt_valid;
  logic                   advance;
  logic                   spawn_blocked;

  assign eligible      = active_q & ~stalled_q;
  assign advance       = !out_valid_q || sched_ready;
  assign spawn_blocked = resume_valid && (resume_wid == spawn_wid) && (resume_tmask == '0);

  rr_warp_arbiter #(
    .NUM_REQ (NUM_WARPS),
    .IDX_W   (WID_W)
  ) u_arb (
    .req_i        (eligible),
    .ptr_i        (rr_q),
    .gnt_onehot_o (gnt_onehot),
    .gnt_idx_o    (gnt_idx),
    .gnt_valid_o  (gnt_valid)
  );

  // Next-state: issue first, then resume, then spawn. Spawn gates on the
  // pre-cycle active bit and yields to a same-cycle halt of the same warp.
  always_comb begin
    active_d    = active_q;
    stalled_d   = stalled_q;
    pc_d        = pc_q;
    tmask_d     = tmask_q;
    uuid_d      = uuid_q;
    rr_d        = rr_q;
    out_valid_d = out_valid_q;
    out_wid_d   = out_wid_q;
    out_pc_d    = out_pc_q;
    out_tmask_d = out_tmask_q;
    out_uuid_d  = out_uuid_q;

    if (advance) begin
      if (gnt_valid) begin
        out_valid_d = 1'b1;
        out_wid_d   = gnt_idx;
        out_pc_d    = pc_q[gnt_idx];
        out_tmask_d = tmask_q[gnt_idx];
        out_uuid_d  = uuid_q;
        stalled_d   = stalled_q | gnt_onehot;
        uuid_d      = uuid_q + UUID_WIDTH'(1);
        rr_d        = gnt_idx;
      end else begin
        out_valid_d = 1'b0;
      end
    end

    if (resume_valid) begin
      stalled_d[resume_wid] = 1'b0;
      pc_d[resume_wid]      = resume_PC;
      tmask_d[resume_wid]   = resume_tmask;
      if (resume_tmask == '0) begin
        active_d[resume_wid] = 1'b0;
      end
    end

    if (spawn_valid && !active_q[spawn_wid] && !spawn_blocked) begin
      active_d[spawn_wid]  = 1'b1;
      stalled_d[spawn_wid] = 1'b0;
      pc_d[spawn_wid]      = spawn_PC;
      tmask_d[spawn_wid]   = spawn_tmask;
    end
  end

  // State registers with synchronous reset; warp 0 comes up active.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q    <= NUM_WARPS'(1);
      stalled_q   <= '0;
      pc_q        <= '{default: '0};
      pc_q[0]     <= STARTUP_PC;
      tmask_q     <= '{default: '0};
      tmask_q[0]  <= NUM_THREADS'(1);
      uuid_q      <= '0;
      rr_q        <= '0;
      out_valid_q <= 1'b0;
      out_wid_q   <= '0;
      out_pc_q    <= '0;
      out_tmask_q <= '0;
      out_uuid_q  <= '0;
    end else begin
      active_q    <= active_d;
      stalled_q   <= stalled_d;
      pc_q        <= pc_d;
      tmask_q     <= tmask_d;
      uuid_q      <= uuid_d;
      rr_q        <= rr_d;
      out_valid_q <= out_valid_d;
      out_wid_q   <= out_wid_d;
      out_pc_q    <= out_pc_d;
      out_tmask_q <= out_tmask_d;
      out_uuid_q  <= out_uuid_d;
    end
  end

  assign sched_valid = out_valid_q;
  assign sched_wid   = out_wid_q;
  assign sched_PC    = out_pc_q;
  assign sched_tmask = out_tmask_q;
  assign sched_uuid  = out_uuid_q;
  assign busy        = |active_q;

  // Resuming a warp that is not stalled is a protocol error upstream.
  a_resume_stalled: assert property (@(posedge clk) disable iff (reset)
    resume_valid |-> stalled_q[resume_wid]);

endmodule

// File: tb/tb_warp_sched_lite.sv
// Self-checking bench for warp_sched_lite: directed scenarios plus random
// traffic compared against a transaction-level scheduler model.
module tb_warp_sched_lite;
  import warp_sched_lite_pkg::*;

  localparam int NW = 4;
  localparam logic [30:0] SPC = 31'h20000000;

  logic        clk = 1'b0;
  logic        reset;
  logic        spawn_valid;
  logic [1:0]  spawn_wid;
  logic [30:0] spawn_PC;
  logic [3:0]  spawn_tmask;
  logic        resume_valid;
  logic [1:0]  resume_wid;
  logic [30:0] resume_PC;
  logic [3:0]  resume_tmask;
  logic        sched_valid;
  logic        sched_ready;
  logic [1:0]  sched_wid;
  logic [30:0] sched_PC;
  logic [3:0]  sched_tmask;
  logic [43:0] sched_uuid;
  logic        busy;

  always #5 clk = ~clk;

  warp_sched_lite #(
    .NUM_WARPS   (4),
    .NUM_THREADS (4),
    .PC_BITS     (31),
    .UUID_WIDTH  (44),
    .STARTUP_PC  (SPC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .spawn_valid  (spawn_valid),
    .spawn_wid    (spawn_wid),
    .spawn_PC     (spawn_PC),
    .spawn_tmask  (spawn_tmask),
    .resume_valid (resume_valid),
    .resume_wid   (resume_wid),
    .resume_PC    (resume_PC),
    .resume_tmask (resume_tmask),
    .sched_valid  (sched_valid),
    .sched_ready  (sched_ready),
    .sched_wid    (sched_wid),
    .sched_PC     (sched_PC),
    .sched_tmask  (sched_tmask),
    .sched_uuid   (sched_uuid),
    .busy         (busy)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: warp table plus the currently presented entry.
  bit          m_active  [NW];
  bit          m_stalled [NW];
  logic [30:0] m_pc      [NW];
  logic [3:0]  m_tm      [NW];
  logic [43:0] m_uuid;
  int          m_rr;
  bit          m_valid;
  sched_data_t m_out;

  function automatic bit m_busy();
    bit b = 0;
    for (int w = 0; w < NW; w++) b |= m_active[w];
    return b;
  endfunction

  function automatic sched_data_t dut_data();
    return {sched_uuid, sched_wid, sched_tmask, sched_PC};
  endfunction

  // One clock of scheduler rules applied to the inputs currently driven.
  function automatic void model_step();
    bit pre_active [NW];
    int g;
    if (reset) begin
      for (int w = 0; w < NW; w++) begin
        m_active[w] = 0; m_stalled[w] = 0; m_pc[w] = '0; m_tm[w] = '0;
      end
      m_active[0] = 1; m_pc[0] = SPC; m_tm[0] = 4'b0001;
      m_uuid = '0; m_rr = 0; m_valid = 0; m_out = '0;
      return;
    end
    pre_active = m_active;
    if (!m_valid || sched_ready) begin
      g = -1;
      for (int n = 1; n <= NW; n++) begin
        int w;
        w = (m_rr + n) % NW;
        if (g < 0 && m_active[w] && !m_stalled[w]) g = w;
      end
      if (g >= 0) begin
        m_out.uuid  = m_uuid;
        m_out.wid   = g[1:0];
        m_out.tmask = m_tm[g];
        m_out.PC    = m_pc[g];
        m_valid     = 1;
        m_stalled[g] = 1;
        m_uuid      = m_uuid + 44'd1;
        m_rr        = g;
      end else begin
        m_valid = 0;
      end
    end
    if (resume_valid) begin
      m_stalled[resume_wid] = 0;
      m_pc[resume_wid] = resume_PC;
      m_tm[resume_wid] = resume_tmask;
      if (resume_tmask == 4'd0) m_active[resume_wid] = 0;
    end
    if (spawn_valid && !pre_active[spawn_wid] &&
        !(resume_valid && resume_wid == spawn_wid && resume_tmask == 4'd0)) begin
      m_active[spawn_wid] = 1;
      m_stalled[spawn_wid] = 0;
      m_pc[spawn_wid] = spawn_PC;
      m_tm[spawn_wid] = spawn_tmask;
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    spawn_valid = 0; spawn_wid = '0; spawn_PC = '0; spawn_tmask = '0;
    resume_valid = 0; resume_wid = '0; resume_PC = '0; resume_tmask = '0;
  endtask

  task automatic test_reset();
    reset = 1; sched_ready = 1; idle_inputs();
    tick(); tick();
    tests++;
    if (sched_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL reset_state: valid=%b busy=%b expected valid=0 busy=1", sched_valid, busy);
    reset = 0;
    tick();
    tests++;
    if ({sched_valid, sched_wid, sched_PC, sched_tmask, sched_uuid} !==
        {1'b1, 2'd0, SPC, 4'b0001, 44'd0}) begin
      fails++;
      $display("FAIL first_issue: valid=%b wid=%0d PC=%0h tmask=%b uuid=%0d expected 1/0/%0h/0001/0",
               sched_valid, sched_wid, sched_PC, sched_tmask, sched_uuid, SPC);
    end
    tick();
    tests++;
    if (sched_valid !== 1'b0) begin
      fails++;
      $display("FAIL stalled_after_issue: valid=%b expected 0", sched_valid);
    end
  endtask

  task automatic test_resume();
    resume_valid = 1; resume_wid = 2'd0; resume_PC = 31'h20000002; resume_tmask = 4'b0001;
    tick();
    idle_inputs();
    tests++;
    if (sched_valid !== 1'b0) begin
      fails++;
      $display("FAIL resume_same_cycle: valid=%b expected 0", sched_valid);
    end
    tick();
    tests++;
    if ({sched_valid, sched_wid, sched_PC, sched_uuid} !== {1'b1, 2'd0, 31'h20000002, 44'd1}) begin
      fails++;
      $display("FAIL resume_reissue: valid=%b wid=%0d PC=%0h uuid=%0d expected 1/0/20000002/1",
               sched_valid, sched_wid, sched_PC, sched_uuid);
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    bit ok = 1;
    for (int c = 0; c < 16; c++) begin
      idle_inputs();
      if (c < 3) begin
        spawn_valid = 1; spawn_wid = 2'(c + 1); spawn_PC = 31'(32'h100 * (c + 1)); spawn_tmask = 4'hF;
      end
      if (m_valid) begin
        resume_valid = 1; resume_wid = m_out.wid; resume_PC = m_out.PC + 31'd1; resume_tmask = m_out.tmask;
      end
      tick();
      tests++;
      if (sched_valid !== m_valid || (m_valid && dut_data() !== m_out)) begin
        fails++;
        $display("FAIL rr_cycle%0d: valid=%b data=%0h expected valid=%b data=%0h",
                 c, sched_valid, dut_data(), m_valid, m_out);
      end
      if (sched_valid === 1'b1) order.push_back(int'(sched_wid));
    end
    idle_inputs();
    tests++;
    if (order.size() < 9) ok = 0;
    else for (int i = order.size() - 8; i < order.size(); i++)
      if (order[i] != (order[i-1] + 1) % NW) ok = 0;
    if (!ok) begin
      fails++;
      $display("FAIL rr_order: got %0d issues, sequence %p, expected steady 0,1,2,3 rotation", order.size(), order);
    end
  endtask

  task automatic test_hold();
    sched_data_t snap;
    sched_ready = 0;
    snap = m_out;
    for (int c = 0; c < 5; c++) begin
      tick();
      tests++;
      if (sched_valid !== 1'b1 || dut_data() !== snap) begin
        fails++;
        $display("FAIL hold_cycle%0d: valid=%b data=%0h expected valid=1 data=%0h", c, sched_valid, dut_data(), snap);
      end
    end
    sched_ready = 1;
    tick();
    tests++;
    if (sched_valid !== 1'b1 || sched_uuid !== snap.uuid + 44'd1 || dut_data() !== m_out) begin
      fails++;
      $display("FAIL hold_release: valid=%b data=%0h expected valid=1 data=%0h uuid=%0d",
               sched_valid, dut_data(), m_out, snap.uuid + 44'd1);
    end
    sched_ready = 0;
    tick();
    tests++;
    if (sched_uuid !== snap.uuid + 44'd1) begin
      fails++;
      $display("FAIL hold_single_issue: uuid=%0d expected %0d", sched_uuid, snap.uuid + 44'd1);
    end
  endtask

  task automatic test_halt();
    bit saw1 = 0;
    int budget;
    sched_ready = 1;
    for (int c = 0; c < 6; c++) tick();
    resume_valid = 1; resume_wid = 2'd1; resume_PC = '0; resume_tmask = 4'd0;
    tick();
    idle_inputs();
    for (int c = 0; c < 20; c++) begin
      idle_inputs();
      if (m_valid && m_out.wid != 2'd1) begin
        resume_valid = 1; resume_wid = m_out.wid; resume_PC = m_out.PC + 31'd2; resume_tmask = 4'hF;
      end
      tick();
      if (sched_valid === 1'b1 && sched_wid === 2'd1) saw1 = 1;
    end
    tests++;
    if (saw1 || sched_valid !== m_valid) begin
      fails++;
      $display("FAIL halted_never_granted: saw_wid1=%b valid=%b expected saw_wid1=0 valid=%b", saw1, sched_valid, m_valid);
    end
    budget = 0;
    while (m_busy() && budget < 40) begin
      idle_inputs();
      for (int w = 0; w < NW; w++)
        if (!resume_valid && m_stalled[w]) begin
          resume_valid = 1; resume_wid = 2'(w); resume_tmask = 4'd0;
        end
      tick();
      budget++;
    end
    idle_inputs();
    tick();
    tests++;
    if (busy !== 1'b0 || budget >= 40) begin
      fails++;
      $display("FAIL halt_all_busy: busy=%b cycles=%0d expected busy=0 within 40", busy, budget);
    end
    spawn_valid = 1; spawn_wid = 2'd0; spawn_PC = 31'h1234; spawn_tmask = 4'b0011;
    tick(); idle_inputs(); tick();
    tests++;
    if ({sched_valid, sched_wid, sched_PC, sched_tmask} !== {1'b1, 2'd0, 31'h1234, 4'b0011}) begin
      fails++;
      $display("FAIL spawn_issue: valid=%b wid=%0d PC=%0h tmask=%b expected 1/0/1234/0011",
               sched_valid, sched_wid, sched_PC, sched_tmask);
    end
    spawn_valid = 1; spawn_wid = 2'd0; spawn_PC = 31'h5555; spawn_tmask = 4'hF;
    resume_valid = 1; resume_wid = 2'd0; resume_PC = '0; resume_tmask = 4'd0;
    tick(); idle_inputs(); tick();
    tests++;
    if (busy !== 1'b0 || sched_valid !== 1'b0) begin
      fails++;
      $display("FAIL halt_beats_spawn: busy=%b valid=%b expected busy=0 valid=0", busy, sched_valid);
    end
    spawn_valid = 1; spawn_wid = 2'd0; spawn_PC = 31'h40; spawn_tmask = 4'b0001;
    tick(); idle_inputs(); tick();
    spawn_valid = 1; spawn_wid = 2'd0; spawn_PC = 31'h77; spawn_tmask = 4'hF;
    tick(); idle_inputs(); tick();
    tests++;
    if (sched_valid !== 1'b0) begin
      fails++;
      $display("FAIL spawn_active_ignored: valid=%b expected 0 (no reissue)", sched_valid);
    end
    resume_valid = 1; resume_wid = 2'd0; resume_PC = 31'h41; resume_tmask = 4'b0001;
    tick(); idle_inputs(); tick();
    tests++;
    if ({sched_valid, sched_PC, sched_tmask} !== {1'b1, 31'h41, 4'b0001} || dut_data() !== m_out) begin
      fails++;
      $display("FAIL spawn_active_pc: valid=%b PC=%0h tmask=%b expected 1/41/0001", sched_valid, sched_PC, sched_tmask);
    end
  endtask

  task automatic test_reset_mid();
    sched_ready = 0;
    tick();
    tests++;
    if (sched_valid !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_pending: valid=%b expected 1", sched_valid);
    end
    reset = 1;
    tick();
    tests++;
    if (sched_valid !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL reset_drop: valid=%b busy=%b expected valid=0 busy=1", sched_valid, busy);
    end
    reset = 0; sched_ready = 1;
    tick();
    tests++;
    if ({sched_valid, sched_wid, sched_PC, sched_tmask, sched_uuid} !==
        {1'b1, 2'd0, SPC, 4'b0001, 44'd0}) begin
      fails++;
      $display("FAIL reset_reissue: valid=%b wid=%0d PC=%0h tmask=%b uuid=%0d expected 1/0/%0h/0001/0",
               sched_valid, sched_wid, sched_PC, sched_tmask, sched_uuid, SPC);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      int cand[$];
      idle_inputs();
      reset = ($urandom_range(0, 499) == 0);
      sched_ready = ($urandom_range(0, 3) != 0);
      if (!reset) begin
        if ($urandom_range(0, 3) == 0) begin
          spawn_valid = 1; spawn_wid = 2'($urandom_range(0, 3));
          spawn_PC = 31'($urandom); spawn_tmask = 4'($urandom);
        end
        for (int w = 0; w < NW; w++) if (m_stalled[w]) cand.push_back(w);
        if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
          resume_valid = 1;
          resume_wid = 2'(cand[$urandom_range(0, cand.size() - 1)]);
          resume_PC = 31'($urandom);
          resume_tmask = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        end
      end
      tick();
      tests++;
      if (sched_valid !== m_valid || busy !== m_busy() || (m_valid && dut_data() !== m_out)) begin
        fails++;
        $display("FAIL random_cycle%0d: valid=%b busy=%b data=%0h expected valid=%b busy=%b data=%0h",
                 c, sched_valid, busy, dut_data(), m_valid, m_busy(), m_out);
      end
    end
    reset = 0;
    idle_inputs();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1; sched_ready = 1;
    idle_inputs();
    test_reset();
    test_resume();
    test_round_robin();
    test_hold();
    test_halt();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
